digit_scroll_reader: RTL and testbench

Playback side of the digit-entry path. Entries are written into the 16×4-bit digit store by the KEY-driven entry block; this block reads them back over a request/valid port and scrolls them right-to-left across HEX5..HEX0 at a fixed step rate. The entry block supplies the number of stored entries. This block owns the displays while playback is active.

---
 rtl/digit_scroll_reader.sv | 219 +++++++++++++++++++++
 tb/tb_digit_scroll_reader.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scroll_reader.sv
// digit_scroll_reader: reads digits back from the 16x4 digit store over a
// request/valid port and scrolls them right-to-left across HEX5..HEX0, one
// step per TICK period, with a blank slot after each full pass.
module digit_scroll_reader #(
   parameter int unsigned TICK = 5_000_000,
   parameter int unsigned AW   = 4
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic [1:0]    KEY,
   input  logic [AW-1:0] last_addr,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [3:0]    rd_data,
   input  logic          rd_valid,
   output logic          busy,
   output logic [6:0]    HEX5,
   output logic [6:0]    HEX4,
   output logic [6:0]    HEX3,
   output logic [6:0]    HEX2,
   output logic [6:0]    HEX1,
   output logic [6:0]    HEX0
);

   localparam int unsigned   CW       = (TICK > 1) ? $clog2(TICK) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHIFT,
      ST_WAIT,
      ST_GAP
   } state_t;

   state_t          state;
   logic [1:0]      key_s0, key_s1, key_d;
   logic            start_ev, rew_ev;
   logic [CW-1:0]   cnt;
   logic            gap, stop;
   logic [3:0]      data_q;
   logic [5:0][4:0] slots;      // {valid, digit}; slots[0] is the newest (HEX0)
   logic [AW-1:0]   last_m1;
   logic            wrap;

   // segment pattern for one slot; blank when the slot holds no digit
   function automatic logic [6:0] seg7(input logic [4:0] slot);
      logic [6:0] s;
      s = 7'b1111111;
      if (slot[4]) begin
         case (slot[3:0])
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
         endcase
      end
      return s;
   endfunction

   // wrap uses >= so a store that shrank below rd_addr mid-pass still wraps;
   // an empty store wraps immediately so the following GAP can drop to IDLE
   always_comb begin
      last_m1 = last_addr - AW'(1);
      wrap    = (last_addr == '0) || (rd_addr >= last_m1);
   end

   // two-flop synchroniser per key, then a registered one-cycle rising-edge event
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         key_s0   <= '0;
         key_s1   <= '0;
         key_d    <= '0;
         start_ev <= 1'b0;
         rew_ev   <= 1'b0;
      end else begin
         key_s0   <= KEY;
         key_s1   <= key_s0;
         key_d    <= key_s1;
         start_ev <= key_s1[0] & ~key_d[0];
         rew_ev   <= key_s1[1] & ~key_d[1];
      end
   end

   // playback sequencer: fetch, shift into the window, wait one step, blank at wrap
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         rd_en   <= 1'b0;
         rd_addr <= '0;
         busy    <= 1'b0;
         cnt     <= '0;
         gap     <= 1'b0;
         stop    <= 1'b0;
         data_q  <= '0;
         slots   <= '0;
      end else if (rew_ev) begin
         // rewind beats everything, including a start event on the same cycle
         state   <= ST_IDLE;
         rd_en   <= 1'b0;
         rd_addr <= '0;
         busy    <= 1'b0;
         cnt     <= '0;
         gap     <= 1'b0;
         stop    <= 1'b0;
         slots   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_ev && (last_addr != '0)) begin
                  state <= ST_FETCH;
                  rd_en <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               // a stop here is deferred until the read has been shifted in
               if (start_ev) stop <= 1'b1;
               if (rd_valid) begin
                  rd_en  <= 1'b0;
                  data_q <= rd_data;
                  state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               slots <= {slots[4:0], {1'b1, data_q}};
               cnt   <= '0;
               if (wrap) begin
                  rd_addr <= '0;
                  gap     <= 1'b1;
               end else begin
                  rd_addr <= rd_addr + AW'(1);
               end
               if (stop || start_ev) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  stop  <= 1'b0;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (start_ev) begin
                  // pending gap is dropped so a resume restarts cleanly at rd_addr
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  gap   <= 1'b0;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (gap) begin
                     state <= ST_GAP;
                  end else begin
                     state <= ST_FETCH;
                     rd_en <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_GAP: begin
               gap <= 1'b0;
               cnt <= '0;
               if (start_ev) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  slots <= {slots[4:0], 5'b0_0000};
                  if (last_addr == '0) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               rd_en <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // registered segment decode of the window; rewind blanks the displays at once
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         HEX5 <= '1;
         HEX4 <= '1;
         HEX3 <= '1;
         HEX2 <= '1;
         HEX1 <= '1;
         HEX0 <= '1;
      end else if (rew_ev) begin
         HEX5 <= '1;
         HEX4 <= '1;
         HEX3 <= '1;
         HEX2 <= '1;
         HEX1 <= '1;
         HEX0 <= '1;
      end else begin
         HEX5 <= seg7(slots[5]);
         HEX4 <= seg7(slots[4]);
         HEX3 <= seg7(slots[3]);
         HEX2 <= seg7(slots[2]);
         HEX1 <= seg7(slots[1]);
         HEX0 <= seg7(slots[0]);
      end
   end

endmodule

// File: tb/tb_digit_scroll_reader.sv
// Self-checking bench for digit_scroll_reader: a behavioural digit store with
// programmable read latency, a queue-style window model, decode vectors and
// directed multi-cycle scenarios.
module tb_digit_scroll_reader;

   localparam int unsigned TICK = 2;
   localparam int unsigned AW   = 4;
   localparam logic [41:0] BLANKWIN = {6{7'b1111111}};

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    KEY = '0;
   logic [AW-1:0] last_addr = '0;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [3:0]    rd_data = '0;
   logic          rd_valid = 1'b0;
   logic          busy;
   logic [6:0]    HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

   int n_checks = 0;
   int n_fail   = 0;

   // store model
   logic [3:0]    mem [16];
   int            lat_cfg = 0;
   int            lat = 0;
   bit            inreq = 1'b0;
   bit            inject = 1'b0;
   logic [3:0]    inj_data = '0;
   int            acc_cnt = 0;
   logic [AW-1:0] last_acc_addr = '0;

   // window model
   bit            model_on = 1'b0;
   int            pend = 0;
   logic [4:0]    mwin [6];
   int            m_addr = 0;
   int            m_n = 1;
   bit            m_gap = 1'b0;

   typedef struct {
      logic [3:0] digit;
      logic [6:0] seg;
   } dec_vec_t;
   dec_vec_t dec_tab [16];

   always #5 clk = ~clk;

   digit_scroll_reader #(.TICK(TICK), .AW(AW)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .KEY      (KEY),
      .last_addr(last_addr),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .busy     (busy),
      .HEX5     (HEX5),
      .HEX4     (HEX4),
      .HEX3     (HEX3),
      .HEX2     (HEX2),
      .HEX1     (HEX1),
      .HEX0     (HEX0)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] exp_seg(input logic [4:0] s);
      if (!s[4]) return 7'b1111111;
      case (s[3:0])
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic logic [41:0] dut_win();
      return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
   endfunction

   function automatic logic [41:0] model_win();
      return {exp_seg(mwin[5]), exp_seg(mwin[4]), exp_seg(mwin[3]),
              exp_seg(mwin[2]), exp_seg(mwin[1]), exp_seg(mwin[0])};
   endfunction

   task automatic shift_in(input logic [4:0] s);
      for (int i = 5; i > 0; i--) mwin[i] = mwin[i-1];
      mwin[0] = s;
   endtask

   task automatic init_model(input int n);
      for (int i = 0; i < 6; i++) mwin[i] = '0;
      m_addr = 0;
      m_n    = n;
      m_gap  = 1'b0;
   endtask

   // the pass is addresses 0..n-1 in order, then one blank before address 0 again
   task automatic model_accept();
      check("rd_addr sequence", 64'(rd_addr), 64'(m_addr));
      if (m_gap) begin
         shift_in(5'b0_0000);
         m_gap = 1'b0;
      end
      shift_in({1'b1, mem[rd_addr]});
      if (m_addr + 1 >= m_n) begin
         m_addr = 0;
         m_gap  = 1'b1;
      end else begin
         m_addr++;
      end
   endtask

   // store: answers each request after lat_cfg cycles (-1 = random 0..3);
   // the window is compared 3 negedges after each accepted read
   always @(negedge clk) begin
      if (pend > 0) begin
         pend--;
         if (pend == 0 && model_on) check("window", 64'(dut_win()), 64'(model_win()));
      end
      if (rd_en) begin
         if (!inreq) begin
            inreq = 1'b1;
            lat   = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
         end
         if (lat == 0) begin
            rd_valid      = 1'b1;
            rd_data       = mem[rd_addr];
            acc_cnt++;
            last_acc_addr = rd_addr;
            if (model_on) model_accept();
            pend = 3;
         end else begin
            rd_valid = 1'b0;
            lat--;
         end
      end else begin
         inreq    = 1'b0;
         rd_valid = inject;
         rd_data  = inject ? inj_data : 4'h0;
      end
   end

   task automatic do_reset();
      model_on = 1'b0;
      pend     = 0;
      lat_cfg  = 0;
      inject   = 1'b0;
      KEY      = '0;
      reset    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic press(input logic [1:0] k);
      @(negedge clk);
      KEY = k;
      @(negedge clk);
      KEY = '0;
   endtask

   task automatic wait_acc(input int target, input string name);
      int t;
      t = 0;
      while (acc_cnt < target && t < 400) begin
         @(posedge clk);
         t++;
      end
      check(name, 64'(acc_cnt >= target), 64'd1);
   endtask

   task automatic load_pattern();
      mem[0] = 4'd2; mem[1] = 4'd4; mem[2] = 4'd0; mem[3] = 4'd5;
      mem[4] = 4'd2; mem[5] = 4'd0; mem[6] = 4'd2;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, t, hi, n;
      bit seen_busy, seen_rd, addr_ok;
      logic [AW-1:0] a0;

      dec_tab[0]  = '{4'd0,  7'b1000000};
      dec_tab[1]  = '{4'd1,  7'b1111001};
      dec_tab[2]  = '{4'd2,  7'b0100100};
      dec_tab[3]  = '{4'd3,  7'b0110000};
      dec_tab[4]  = '{4'd4,  7'b0011001};
      dec_tab[5]  = '{4'd5,  7'b0010010};
      dec_tab[6]  = '{4'd6,  7'b0000010};
      dec_tab[7]  = '{4'd7,  7'b1111000};
      dec_tab[8]  = '{4'd8,  7'b0000000};
      dec_tab[9]  = '{4'd9,  7'b0010000};
      dec_tab[10] = '{4'd10, 7'b0111111};
      dec_tab[11] = '{4'd11, 7'b0111111};
      dec_tab[12] = '{4'd12, 7'b0111111};
      dec_tab[13] = '{4'd13, 7'b0111111};
      dec_tab[14] = '{4'd14, 7'b0111111};
      dec_tab[15] = '{4'd15, 7'b0111111};
      for (int i = 0; i < 16; i++) mem[i] = '0;
      init_model(1);

      // reset state
      do_reset();
      check("reset rd_en", 64'(rd_en), 64'd0);
      check("reset rd_addr", 64'(rd_addr), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset hex", 64'(dut_win()), 64'(BLANKWIN));

      // segment decode vectors, one digit per run
      for (int i = 0; i < 16; i++) begin
         do_reset();
         mem[0]    = dec_tab[i].digit;
         last_addr = 4'd1;
         base      = acc_cnt;
         press(2'b01);
         wait_acc(base + 1, "decode read");
         repeat (2) @(posedge clk);
         #1;
         check($sformatf("decode %0d", i), 64'(HEX0), 64'(dec_tab[i].seg));
         if (i == 0) check("decode others blank", 64'(dut_win() >> 7), 64'(BLANKWIN >> 7));
      end

      // scroll of {2,4,0,5,2,0,2} with gap
      do_reset();
      load_pattern();
      last_addr = 4'd7;
      init_model(7);
      model_on = 1'b1;
      base     = acc_cnt;
      press(2'b01);
      wait_acc(base + 1, "scroll first read");
      repeat (2) @(posedge clk);
      #1;
      check("scroll first HEX0", 64'(HEX0), 64'(7'b0100100));
      wait_acc(base + 7, "scroll 7 reads");
      repeat (2) @(posedge clk);
      #1;
      check("scroll full window", 64'(dut_win()),
            64'({7'b0011001, 7'b1000000, 7'b0010010, 7'b0100100, 7'b1000000, 7'b0100100}));
      t = 0;
      while (HEX0 !== 7'b1111111 && t < 12) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("gap blanks HEX0", 64'(HEX0), 64'(7'b1111111));
      check("gap HEX1 holds last", 64'(HEX1), 64'(7'b0100100));
      wait_acc(base + 8, "scroll after gap");
      repeat (2) @(posedge clk);
      #1;
      check("after gap HEX0", 64'(HEX0), 64'(7'b0100100));
      check("after gap HEX1", 64'(HEX1), 64'(7'b1111111));
      wait_acc(base + 10, "scroll continue");
      repeat (4) @(negedge clk);

      // empty store: start ignored
      do_reset();
      last_addr = '0;
      press(2'b01);
      seen_busy = 1'b0;
      seen_rd   = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         seen_busy |= busy;
         seen_rd   |= rd_en;
      end
      check("empty busy", 64'(seen_busy), 64'd0);
      check("empty rd_en", 64'(seen_rd), 64'd0);
      check("empty hex", 64'(dut_win()), 64'(BLANKWIN));

      // stop during a slow FETCH
      do_reset();
      mem[0] = 4'd7; mem[1] = 4'd3; mem[2] = 4'd9;
      last_addr = 4'd3;
      lat_cfg   = 5;
      press(2'b01);
      t = 0;
      while (!rd_en && t < 30) begin
         @(negedge clk);
         t++;
      end
      check("slow fetch started", 64'(rd_en), 64'd1);
      hi      = 0;
      addr_ok = 1'b1;
      a0      = rd_addr;
      KEY     = 2'b01;
      for (int c = 0; c < 20 && rd_en; c++) begin
         hi++;
         if (rd_addr !== a0) addr_ok = 1'b0;
         @(negedge clk);
         KEY = '0;
      end
      check("slow fetch rd_en cycles", 64'(hi), 64'd6);
      check("slow fetch addr stable", 64'(addr_ok), 64'd1);
      repeat (4) @(negedge clk);
      check("stop busy", 64'(busy), 64'd0);
      check("stop HEX0", 64'(HEX0), 64'(7'b1111000));
      check("stop rd_addr", 64'(rd_addr), 64'd1);
      lat_cfg = 0;
      base    = acc_cnt;
      press(2'b01);
      wait_acc(base + 1, "resume read");
      check("resume address", 64'(last_acc_addr), 64'd1);

      // rewind while waiting between steps
      do_reset();
      load_pattern();
      last_addr = 4'd7;
      base      = acc_cnt;
      press(2'b01);
      wait_acc(base + 3, "rewind setup");
      repeat (2) @(posedge clk);
      #1;
      check("busy before rewind", 64'(busy), 64'd1);
      press(2'b10);
      t = 0;
      while (busy && t < 10) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("rewind busy", 64'(busy), 64'd0);
      check("rewind rd_addr", 64'(rd_addr), 64'd0);
      check("rewind rd_en", 64'(rd_en), 64'd0);
      check("rewind hex", 64'(dut_win()), 64'(BLANKWIN));
      @(negedge clk);
      inj_data = 4'd5;
      inject   = 1'b1;
      @(negedge clk);
      inject = 1'b0;
      repeat (3) @(negedge clk);
      check("late valid hex", 64'(dut_win()), 64'(BLANKWIN));
      check("late valid busy", 64'(busy), 64'd0);

      // start and rewind together while idle
      press(2'b11);
      seen_busy = 1'b0;
      seen_rd   = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         seen_busy |= busy;
         seen_rd   |= rd_en;
      end
      check("start+rewind busy", 64'(seen_busy), 64'd0);
      check("start+rewind rd_en", 64'(seen_rd), 64'd0);
      check("start+rewind rd_addr", 64'(rd_addr), 64'd0);

      // store shrinks below rd_addr mid-pass
      do_reset();
      for (int i = 0; i < 16; i++) mem[i] = 4'(i % 10);
      last_addr = 4'd8;
      base      = acc_cnt;
      press(2'b01);
      wait_acc(base + 6, "shrink setup");
      #1;
      last_addr = 4'd3;
      wait_acc(base + 7, "shrink next read");
      check("shrink wraps to 0", 64'(last_acc_addr), 64'd0);

      // asynchronous reset in the middle of WAIT
      do_reset();
      load_pattern();
      last_addr = 4'd7;
      base      = acc_cnt;
      press(2'b01);
      wait_acc(base + 2, "async setup");
      repeat (2) @(posedge clk);
      #1;
      check("running before reset", 64'(busy), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      check("async rd_en", 64'(rd_en), 64'd0);
      check("async rd_addr", 64'(rd_addr), 64'd0);
      check("async busy", 64'(busy), 64'd0);
      check("async hex", 64'(dut_win()), 64'(BLANKWIN));
      @(negedge clk);
      reset = 1'b0;

      // random stores, lengths and read latencies against the window model
      for (int trial = 0; trial < 4; trial++) begin
         do_reset();
         for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
         n         = int'($urandom_range(1, 16));
         last_addr = 4'(n);
         init_model(n);
         lat_cfg  = -1;
         model_on = 1'b1;
         base     = acc_cnt;
         press(2'b01);
         wait_acc(base + n + 4, "random run");
         repeat (4) @(negedge clk);
      end
      do_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
